code_entry_buffer: RTL

- Parametrised keypad code-entry register. Successor to the fixed 4-digit parallel-load register.
- Accepts digits one at a time from the keypad decoder and shifts them in, display style.
- Supports backspace, clear, parallel preload and an inactivity timeout.
- Presents the assembled code plus count/full/done flags to the comparator and display stages.

---
 rtl/code_entry_pkg.sv | 19 +
 rtl/inactivity_timer.sv | 32 +++
 rtl/code_entry_buffer.sv | 115 +++++++++++
 3 files changed

// File: rtl/code_entry_pkg.sv
// Shared types and width helpers for the keypad code-entry register and its
// inactivity timer.
package code_entry_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic int count_w(input int digits);
        return $clog2(digits + 1);
    endfunction

    function automatic int timer_w(input int timeout_cyc);
        return $clog2(timeout_cyc);
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter with synchronous clear and enable; tc is high while the
// count sits at TERMINAL-1, and the counter wraps to zero on that edge.
module inactivity_timer
    import code_entry_pkg::*;
#(
    parameter int TERMINAL = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tc
);

    localparam int W = timer_w(TERMINAL);
    localparam logic [W-1:0] LAST = W'(TERMINAL - 1);

    logic [W-1:0] cnt;

    assign tc = enable && (cnt == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/code_entry_buffer.sv
// Keypad code-entry shift register: digits shift in display-style, with
// clear/load/backspace/key priority, inactivity auto-clear and status pulses.
module code_entry_buffer
    import code_entry_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [DIGIT_W-1:0]            key_code,
    input  logic                          backspace,
    input  logic                          clear,
    input  logic                          load,
    input  logic [DIGITS*DIGIT_W-1:0]     load_data,
    output logic [DIGITS*DIGIT_W-1:0]     code_out,
    output logic [count_w(DIGITS)-1:0]    count,
    output logic                          full,
    output logic                          entry_done,
    output logic                          overflow,
    output logic                          timeout
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int CW     = count_w(DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_d;
    logic [CW-1:0]     count_d;
    logic              done_d, ovf_d, to_d;
    logic              cmd, tc;

    assign cmd  = clear | load | backspace | key_valid;
    assign full = (state_q == FULL);

    inactivity_timer #(
        .TERMINAL (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (cmd || (state_q != ENTRY)),
        .enable (state_q == ENTRY),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        code_d  = code_out;
        count_d = count;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        to_d    = 1'b0;

        if (clear) begin
            code_d  = '0;
            count_d = '0;
        end else if (load) begin
            code_d  = load_data;
            count_d = CNT_MAX;
        end else if (backspace) begin
            if (state_q != IDLE) begin
                code_d  = code_out >> DIGIT_W;
                count_d = count - 1'b1;
            end
        end else if (key_valid) begin
            if (state_q != FULL) begin
                code_d  = {code_out[CODE_W-DIGIT_W-1:0], key_code};
                count_d = count + 1'b1;
                done_d  = (count_d == CNT_MAX);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (tc) begin
            code_d  = '0;
            count_d = '0;
            to_d    = 1'b1;
        end

        // State is derived from the next count so the two can never disagree.
        if (count_d == '0) begin
            state_d = IDLE;
        end else if (count_d == CNT_MAX) begin
            state_d = FULL;
        end else begin
            state_d = ENTRY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_out   <= '0;
            count      <= '0;
            entry_done <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            code_out   <= code_d;
            count      <= count_d;
            entry_done <= done_d;
            overflow   <= ovf_d;
            timeout    <= to_d;
        end
    end

endmodule
